// File: rtl/axis_requantizer.sv
// axis_requantizer
// Two-stage AXI-Stream requantizer. Each 16-bit product lane is rounded,
// right-shifted by a per-packet shift amount and saturated to 8 bits.
// Saturated-lane and delivered-packet counters are kept for software.
module axis_requantizer #(
  parameter int LANES        = 16,
  parameter int PROD_WIDTH   = 16,
  parameter int SAMPLE_WIDTH = 8,
  parameter int SHIFT_WIDTH  = 4
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic                          s_axis_mm2s_tvalid,
  output logic                          s_axis_mm2s_tready,
  input  logic [LANES*PROD_WIDTH-1:0]   s_axis_mm2s_tdata,
  input  logic [LANES-1:0]              s_axis_mm2s_tkeep,
  input  logic                          s_axis_mm2s_tlast,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          cnt_clr,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [LANES*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic [LANES-1:0]              m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [31:0]                   sat_count,
  output logic [15:0]                   pkt_count
);

  // One extra bit so that p + rounding constant never overflows.
  localparam int T_WIDTH = PROD_WIDTH + 1;
  localparam int CNT_W   = $clog2(LANES + 1);
  localparam logic [T_WIDTH-1:0] SAT_MAX = T_WIDTH'((1 << SAMPLE_WIDTH) - 1);

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [SHIFT_WIDTH-1:0]          r_shift_q;

  // Stage 1: shifted lane values (already reflect the packet's shift)
  logic                            r_v1;
  logic [T_WIDTH-1:0]              r_t1 [LANES];
  logic [LANES-1:0]                r_keep1;
  logic                            r_last1;

  // Stage 2: saturated samples plus the beat's saturated-lane count
  logic                            r_v2;
  logic [LANES*SAMPLE_WIDTH-1:0]   r_data2;
  logic [LANES-1:0]                r_keep2;
  logic                            r_last2;
  logic [CNT_W-1:0]                r_sat_n2;

  logic [31:0]                     r_sat_count;
  logic [15:0]                     r_pkt_count;

  logic                            w_s_hs;
  logic                            w_m_hs;
  logic                            w_load2;
  logic [SHIFT_WIDTH-1:0]          w_shift_use;
  logic [T_WIDTH-1:0]              w_round;
  logic [T_WIDTH-1:0]              w_t [LANES];
  logic [LANES*SAMPLE_WIDTH-1:0]   w_out;
  logic [LANES-1:0]                w_sat;
  logic [CNT_W-1:0]                w_sat_n;

  // Accept while either stage has room or the pipe is about to move.
  assign s_axis_mm2s_tready = resetn & (~r_v1 | ~r_v2 | m_axis_tready);
  assign w_s_hs  = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
  assign w_m_hs  = r_v2 & m_axis_tready;
  assign w_load2 = r_v1 & (~r_v2 | m_axis_tready);

  // The first beat of a packet uses the live shift; later beats use the latch.
  assign w_shift_use = (r_state == ST_IDLE) ? shift : r_shift_q;
  assign w_round = (w_shift_use == '0) ? '0
                 : (T_WIDTH'(1) << (w_shift_use - SHIFT_WIDTH'(1)));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_t[gi] = s_axis_mm2s_tkeep[gi]
        ? ((T_WIDTH'(s_axis_mm2s_tdata[gi*PROD_WIDTH +: PROD_WIDTH]) + w_round) >> w_shift_use)
        : '0;
      assign w_sat[gi] = r_keep1[gi] & (r_t1[gi] > SAT_MAX);
      assign w_out[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        (r_t1[gi] > SAT_MAX) ? {SAMPLE_WIDTH{1'b1}} : r_t1[gi][SAMPLE_WIDTH-1:0];
    end
  endgenerate

  // Count saturated lanes of the beat sitting in stage 1.
  always_comb begin
    w_sat_n = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sat_n = w_sat_n + CNT_W'(w_sat[i]);
    end
  end

  // Packet state: tlast on an accepted beat always ends the packet.
  always_comb begin
    w_state_next = r_state;
    if (w_s_hs) begin
      w_state_next = s_axis_mm2s_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Packet state register and per-packet shift latch.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_shift_q <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_s_hs && r_state == ST_IDLE) begin
        r_shift_q <= shift;
      end
    end
  end

  // Stage 1: capture rounded/shifted lanes on input handshake.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_v1    <= 1'b0;
      r_keep1 <= '0;
      r_last1 <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_t1[i] <= '0;
      end
    end else if (w_s_hs) begin
      r_v1    <= 1'b1;
      r_keep1 <= s_axis_mm2s_tkeep;
      r_last1 <= s_axis_mm2s_tlast;
      for (int i = 0; i < LANES; i++) begin
        r_t1[i] <= w_t[i];
      end
    end else if (w_load2) begin
      r_v1 <= 1'b0;
    end
  end

  // Stage 2: saturate and hold the output beat until it is taken.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_v2     <= 1'b0;
      r_data2  <= '0;
      r_keep2  <= '0;
      r_last2  <= 1'b0;
      r_sat_n2 <= '0;
    end else if (w_load2) begin
      r_v2     <= 1'b1;
      r_data2  <= w_out;
      r_keep2  <= r_keep1;
      r_last2  <= r_last1;
      r_sat_n2 <= w_sat_n;
    end else if (w_m_hs) begin
      r_v2 <= 1'b0;
    end
  end

  // Software counters; a clear wins over any same-cycle increment.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_sat_count <= '0;
      r_pkt_count <= '0;
    end else if (cnt_clr) begin
      r_sat_count <= '0;
      r_pkt_count <= '0;
    end else if (w_m_hs) begin
      r_sat_count <= r_sat_count + 32'(r_sat_n2);
      if (r_last2) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = r_v2;
  assign m_axis_tdata  = r_data2;
  assign m_axis_tkeep  = r_keep2;
  assign m_axis_tlast  = r_last2;
  assign sat_count     = r_sat_count;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_axis_requantizer.sv
// Testbench for axis_requantizer: table-driven single-beat vectors, directed
// shift-latch / reset / counter-clear sequences, and randomized traffic
// against a behavioural reference model.
module tb_axis_requantizer;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         s_tvalid;
  logic         s_tready;
  logic [255:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tlast;
  logic [3:0]   shift;
  logic         cnt_clr;
  logic         m_tvalid;
  logic         m_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic [31:0]  sat_count;
  logic [15:0]  pkt_count;

  axis_requantizer dut (
    .CLK                (CLK),
    .resetn             (resetn),
    .s_axis_mm2s_tvalid (s_tvalid),
    .s_axis_mm2s_tready (s_tready),
    .s_axis_mm2s_tdata  (s_tdata),
    .s_axis_mm2s_tkeep  (s_tkeep),
    .s_axis_mm2s_tlast  (s_tlast),
    .shift              (shift),
    .cnt_clr            (cnt_clr),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tkeep       (m_tkeep),
    .m_axis_tlast       (m_tlast),
    .sat_count          (sat_count),
    .pkt_count          (pkt_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    int           satn;
  } beat_t;

  typedef struct {
    int           sh;
    logic [255:0] p;
    logic [15:0]  keep;
    logic [127:0] exp_data;
    int           exp_sat;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  int          lane0_q[$];
  bit          model_on = 0;
  bit          in_pkt_m = 0;
  int          pkt_shift_m = 0;
  logic [31:0] sat_m = 0;
  logic [15:0] pkt_m = 0;
  int          inflight = 0;
  int          acc_cnt = 0;
  bit          prev_stall = 0;
  logic [127:0] prev_data;
  logic [15:0] prev_keep;
  logic        prev_last;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference: floor((p + half) / 2^sh), saturated to 255, masked lanes 0.
  function automatic beat_t ref_beat(input logic [255:0] p, input logic [15:0] keep,
                                     input logic last, input int sh);
    beat_t b;
    int    t;
    int    half;
    b.data = '0;
    b.keep = keep;
    b.last = last;
    b.satn = 0;
    half = (sh == 0) ? 0 : (1 << (sh - 1));
    for (int k = 0; k < 16; k++) begin
      if (keep[k]) begin
        t = (int'(p[k*16 +: 16]) + half) / (1 << sh);
        if (t > 255) begin
          b.data[k*8 +: 8] = 8'hFF;
          b.satn++;
        end else begin
          b.data[k*8 +: 8] = t[7:0];
        end
      end
    end
    return b;
  endfunction

  function automatic vec_t mkvec(input int sh, input logic [255:0] p, input logic [15:0] keep,
                                 input logic [127:0] d, input int s);
    vec_t v;
    v.sh = sh; v.p = p; v.keep = keep; v.exp_data = d; v.exp_sat = s;
    return v;
  endfunction

  // One clock: sample at negedge, update the model, then step past posedge.
  task automatic cycle();
    bit    s_hs;
    bit    m_hs;
    beat_t e;
    @(negedge CLK);
    s_hs = s_tvalid & s_tready;
    m_hs = m_tvalid & m_tready;
    if (model_on) begin
      chk("tready_rule", s_tready, (inflight < 2) || m_tready);
      chk("sat_count", sat_count, sat_m);
      chk("pkt_count", pkt_count, pkt_m);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, prev_data);
        chk("stall_keep", m_tkeep, prev_keep);
        chk("stall_last", m_tlast, prev_last);
      end
      if (m_hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.data);
          chk("out_keep", m_tkeep, e.keep);
          chk("out_last", m_tlast, e.last);
          sat_m = sat_m + 32'(e.satn);
          if (e.last) pkt_m = pkt_m + 16'd1;
        end
        lane0_q.push_back(int'(m_tdata[7:0]));
      end
      if (cnt_clr) begin
        sat_m = 0;
        pkt_m = 0;
      end
      if (s_hs) begin
        if (!in_pkt_m) pkt_shift_m = int'(shift);
        exp_q.push_back(ref_beat(s_tdata, s_tkeep, s_tlast, pkt_shift_m));
        in_pkt_m = !s_tlast;
        acc_cnt++;
      end
      inflight = inflight + int'(s_hs) - int'(m_hs);
      prev_stall = m_tvalid & !m_tready;
      prev_data = m_tdata;
      prev_keep = m_tkeep;
      prev_last = m_tlast;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < 50 && (exp_q.size() != 0 || inflight != 0); c++) cycle();
    chk("drain_empty", 1'(exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    bit   seen;
    int   cyc;

    vecs[0] = mkvec(8, {16{16'h7F80}}, 16'hFFFF, {16{8'h80}}, 0);
    vecs[1] = mkvec(0, {224'h0, 16'h0100, 16'h00C8}, 16'hFFFF, {112'h0, 8'hFF, 8'hC8}, 1);
    vecs[2] = mkvec(4, {16{16'hFFFF}}, 16'hFFFF, {16{8'hFF}}, 16);
    vecs[3] = mkvec(4, {224'h0, 16'h0018, 16'h0017}, 16'hFFFF, {112'h0, 8'h02, 8'h01}, 0);
    vecs[4] = mkvec(4, {16{16'hFFFF}}, 16'h00FF, {64'h0, {8{8'hFF}}}, 8);
    vecs[5] = mkvec(15, {16{16'h4000}}, 16'hF0F0,
                    {32'h01010101, 32'h0, 32'h01010101, 32'h0}, 0);
    vecs[6] = mkvec(1, {16{16'h01FF}}, 16'hFFFF, {16{8'hFF}}, 16);
    vecs[7] = mkvec(1, {16{16'h01FE}}, 16'hFFFF, {16{8'hFF}}, 0);

    resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    shift = '0; cnt_clr = 1'b0; m_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 128'h0);
    chk("rst_m_tkeep", m_tkeep, 16'h0);
    chk("rst_m_tlast", m_tlast, 1'b0);
    chk("rst_sat", sat_count, 32'h0);
    chk("rst_pkt", pkt_count, 16'h0);
    @(posedge CLK); #1;
    resetn = 1'b1;

    // Table-driven single-beat packets with explicit expectations
    for (int i = 0; i < 8; i++) begin
      shift = 4'(vecs[i].sh); s_tdata = vecs[i].p; s_tkeep = vecs[i].keep;
      s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      @(negedge CLK);
      chk("tbl_s_tready", s_tready, 1'b1);
      @(posedge CLK); #1;
      s_tvalid = 1'b0;
      lat = 0; seen = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge CLK);
        lat++;
        if (m_tvalid) seen = 1;
      end
      chk($sformatf("tbl%0d_latency", i), lat, 2);
      chk($sformatf("tbl%0d_data", i), m_tdata, vecs[i].exp_data);
      chk($sformatf("tbl%0d_keep", i), m_tkeep, vecs[i].keep);
      chk($sformatf("tbl%0d_last", i), m_tlast, 1'b1);
      sat_m = sat_m + 32'(vecs[i].exp_sat);
      pkt_m = pkt_m + 16'd1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk($sformatf("tbl%0d_sat_count", i), sat_count, sat_m);
      chk($sformatf("tbl%0d_pkt_count", i), pkt_count, pkt_m);
      @(posedge CLK); #1;
    end

    // Three-beat packet with shift changed mid-packet, then a new packet
    model_on = 1;
    lane0_q.delete();
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = {16{16'h0400}}; s_tkeep = 16'hFFFF;
    s_tlast = 1'b0; shift = 4'd8;
    cycle();
    shift = 4'd2;
    cycle();
    s_tlast = 1'b1;
    cycle();
    cycle();
    drain();
    chk("shiftchg_count", lane0_q.size(), 4);
    if (lane0_q.size() == 4) begin
      chk("shiftchg_b0", lane0_q[0], 32'h04);
      chk("shiftchg_b1", lane0_q[1], 32'h04);
      chk("shiftchg_b2", lane0_q[2], 32'h04);
      chk("shiftchg_next_pkt", lane0_q[3], 32'hFF);
    end

    // Randomized traffic with 50% downstream backpressure
    cyc = 0;
    acc_cnt = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 16; k++) begin
        s_tdata[k*16 +: 16] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 600));
      end
      s_tkeep = 16'($urandom);
      s_tlast = ($urandom_range(0, 3) == 0);
      shift = 4'($urandom_range(0, 15));
      m_tready = 1'($urandom_range(0, 1));
      cycle();
      cyc++;
    end
    chk("rand_beats_accepted", 1'(acc_cnt >= 1000), 1'b1);
    drain();

    // Reset mid-packet with two beats held
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = {16{16'h0400}}; s_tkeep = 16'hFFFF;
    s_tlast = 1'b0; shift = 4'd8;
    cycle();
    cycle();
    s_tvalid = 1'b0;
    chk("pre_rst_held", inflight, 2);
    resetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    chk("midrst_s_tready", s_tready, 1'b0);
    chk("midrst_m_tdata", m_tdata, 128'h0);
    model_on = 0;
    exp_q.delete();
    inflight = 0; in_pkt_m = 0; sat_m = 0; pkt_m = 0; prev_stall = 0;
    repeat (2) @(posedge CLK);
    #1;
    resetn = 1'b1;
    model_on = 1;
    m_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("post_rst_no_output", m_tvalid, 1'b0);
      @(posedge CLK); #1;
    end
    lane0_q.delete();
    s_tvalid = 1'b1; s_tlast = 1'b1; shift = 4'd2;
    cycle();
    drain();
    chk("post_rst_beats", lane0_q.size(), 1);
    if (lane0_q.size() == 1) chk("post_rst_fresh_shift", lane0_q[0], 32'hFF);

    // cnt_clr on a tlast handshake cycle
    model_on = 0;
    s_tvalid = 1'b1; s_tdata = {16{16'h0100}}; s_tkeep = 16'hFFFF;
    s_tlast = 1'b1; shift = 4'd0; m_tready = 1'b1;
    @(posedge CLK); #1;
    s_tvalid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge CLK);
      if (m_tvalid) seen = 1;
    end
    chk("clr_beat_seen", seen, 1'b1);
    chk("clr_pkt_before", pkt_count, pkt_m);
    cnt_clr = 1'b1;
    @(posedge CLK); #1;
    cnt_clr = 1'b0;
    @(negedge CLK);
    chk("clr_pkt_after", pkt_count, 16'h0);
    chk("clr_sat_after", sat_count, 32'h0);
    chk("clr_m_tvalid_after", m_tvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_requantizer.md
# axis_requantizer

Streaming requantizer that sits downstream of the MM2S DMA on the playback path. It takes the full-precision product stream (16 lanes of 16-bit unsigned products, 256 bits per beat) and returns it to the 128-bit sample domain. Each lane is rounded, right-shifted and saturated to 8 bits. The block is a two-stage AXI-Stream pipeline with full backpressure and per-packet shift latching, and it keeps saturation and packet counters for software.

## Interface
Parameters:
- LANES, 16, number of sample lanes per beat
- PROD_WIDTH, 16, input lane width (product width)
- SAMPLE_WIDTH, 8, output lane width
- SHIFT_WIDTH, 4, width of shift control

Ports (width expressions use parameters):
- CLK  in  1  single clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- s_axis_mm2s_tvalid  in  1  input beat valid
- s_axis_mm2s_tready  out  1  input beat accepted when high with tvalid
- s_axis_mm2s_tdata  in  LANES*PROD_WIDTH  lane k at bits [k*PROD_WIDTH +: PROD_WIDTH]
- s_axis_mm2s_tkeep  in  LANES  one bit per 16-bit lane
- s_axis_mm2s_tlast  in  1  last beat of packet
- shift  in  SHIFT_WIDTH  right-shift amount 0..15, quasi-static
- cnt_clr  in  1  synchronous clear of both counters
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  LANES*SAMPLE_WIDTH  lane k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- m_axis_tkeep  out  LANES  one bit per 8-bit lane (byte)
- m_axis_tlast  out  1  last beat of packet
- sat_count  out  32  count of saturated valid lanes, wraps at 2^32
- pkt_count  out  16  count of tlast beats delivered on m_axis, wraps at 2^16

## Operation
- Packet state: two states. IDLE means the next accepted beat is the first beat of a packet. IN_PKT means a packet is in progress.
  - IDLE to IN_PKT on an accepted beat with tlast=0.
  - IN_PKT to IDLE on an accepted beat with tlast=1.
  - An accepted beat with tlast=1 in IDLE, which is a single-beat packet, stays in IDLE.
- Shift latch: shift_q captures `shift` on every beat accepted in IDLE. All beats of a packet use that packet's shift_q, even if `shift` changes mid-packet.
- Stage 1, registered on acceptance, per lane:
  - r = 0 if shift_q = 0, else 1 << (shift_q-1).
  - t = (p + r) >> shift_q, computed at 17 bits with no overflow.
  - Lanes with tkeep=0 force t = 0.
  - tkeep, tlast and shift_q travel with the beat.
- Stage 2, registered:
  - out = 8'hFF if t > 255, else t[7:0].
  - sat flag per lane = valid lane and t > 255.
  - The number of saturated lanes in the beat (0..16) is carried with the beat.
- Output: m_axis_tdata, tkeep and tlast come from stage 2. tkeep passes lane for lane. Zeroed lanes keep tkeep=0.
- Counters:
  - Both counters update on the m_axis handshake (tvalid & tready).
  - sat_count adds the beat's saturated-lane count.
  - pkt_count increments if tlast is set on that beat.
  - cnt_clr has priority: both counters go to 0 that cycle, and any handshake increment in the same cycle is dropped.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - All pipeline valids go to 0; m_axis_tvalid=0.
  - m_axis_tdata, tkeep and tlast go to 0.
  - s_axis_mm2s_tready=0 while resetn is low.
  - sat_count=0, pkt_count=0, state=IDLE, shift_q=0.
- s_axis_mm2s_tready = resetn & (~v1 | ~v2 | m_axis_tready).
  - The combinational path from m_axis_tready is allowed.
- Pipeline advance:
  - Stage 2 loads when v1 & (~v2 | m_axis_tready).
  - Stage 1 loads on input handshake.
  - v1 clears when stage 1 moves to stage 2 and no new input is accepted.
  - v2 clears on an output handshake when stage 1 is empty.
- Latency: a beat accepted at edge N is presented with m_axis_tvalid=1 after edge N+2 when there is no stall.
- Throughput: one beat per cycle under continuous tvalid and tready.
- Backpressure:
  - With m_axis_tready=0, up to 2 beats are held and s_axis_mm2s_tready then drops.
  - No beat is lost or duplicated.
  - m_axis_tdata, tkeep and tlast stay stable while tvalid=1 and tready=0.
- Reset mid-packet discards in-flight beats and returns the packet state to IDLE.

## Test plan
- shift=8, one-beat packet with all lanes 0x7F80, tkeep=16'hFFFF, tlast=1.
  - Out lanes = 0x80; out tkeep=16'hFFFF; out tlast=1.
  - Output appears 2 cycles after acceptance.
  - pkt_count=1, sat_count=0.
- shift=0: lane0 = 0x00C8, lane1 = 0x0100, other lanes 0.
  - Out lane0 = 0xC8 and lane1 = 0xFF.
  - sat_count increments by 1.
- shift=4 with all lanes 0xFFFF: all out lanes = 0xFF and sat_count increments by 16.
  - With shift=4, 0x0017 gives 0x01 and 0x0018 gives 0x02 (rounding check).
- Three-beat packet with `shift` changed from 8 to 2 after beat 1.
  - All three beats use shift 8.
  - The next packet uses shift 2.
  - pkt_count increments by 1 per packet.
- Random m_axis_tready (50%) over 1000 beats with random tkeep.
  - Output sequence matches the reference model exactly.
  - Masked lanes are 0.
  - Output data is stable during stalls.
  - s_axis_mm2s_tready falls only when 2 beats are held.
- Two cases for reset and cnt_clr:
  - Assert resetn=0 mid-packet with 2 beats in flight. m_axis_tvalid=0 immediately, with no output after release. The next beat latches a fresh shift.
  - Assert cnt_clr on a tlast handshake cycle. pkt_count=0 afterward.
